// File: rtl/sdes_cipher_core.sv
// sdes_cipher_core: sequential S-DES encrypt/decrypt engine, one 8-bit block
// per transaction: IP -> fk(Ka) -> SW -> fk(Kb) -> IP^-1.
// Optional build macro SDES_ROUND_DEBUG_EN adds dbg_round / dbg_state outputs.
//
// Handshake: an input block transfers on a rising edge where in_valid and
// in_ready are both high; a result transfers on a rising edge where out_valid
// and out_ready are both high. out_valid/data_out hold steady until that
// transfer, and in_ready stays low from accept until the result is taken.
module sdes_cipher_core #(
  parameter int ROUND_STALL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mode,
  input  logic [7:0] data_in,
  input  logic [7:0] key_1,
  input  logic [7:0] key_2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] data_out
`ifdef SDES_ROUND_DEBUG_EN
  ,
  output logic [7:0] dbg_round,
  output logic [1:0] dbg_state
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_R1, S_ST1, S_R2, S_ST2, S_DONE
  } state_t;

  localparam bit         HAS_STALL  = (ROUND_STALL != 0);
  localparam logic [1:0] STALL_LAST = (ROUND_STALL == 0) ? 2'd0 : 2'(ROUND_STALL - 1);

  localparam logic [1:0] S0_TBL [0:15] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };
  localparam logic [1:0] S1_TBL [0:15] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  // S-DES bit n (1-based) lives at vector index width-n.
  function automatic logic [7:0] ip(input logic [7:0] d);
    return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
  endfunction

  function automatic logic [7:0] sw(input logic [7:0] d);
    return {d[3:0], d[7:4]};
  endfunction

  function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] k);
    logic [7:0] x;
    logic [3:0] s;
    logic [3:0] p;
    x = {d[0], d[3], d[2], d[1], d[2], d[1], d[0], d[3]} ^ k;
    s = {S0_TBL[{x[7], x[4], x[6], x[5]}], S1_TBL[{x[3], x[0], x[2], x[1]}]};
    p = {s[2], s[0], s[1], s[3]};
    return {d[7:4] ^ p, d[3:0]};
  endfunction

  state_t     state, next_state;
  logic [1:0] stall_cnt;
  logic       live;
  logic [7:0] work, ka, kb;
  logic [7:0] fk_key, fk_out;
  logic       accept, stall_done;

  assign in_ready   = live && (state == S_IDLE);
  assign accept     = in_valid && in_ready;
  assign stall_done = (stall_cnt == STALL_LAST);
  // Single shared round function: Ka in R1, Kb for the second round.
  assign fk_key     = (state == S_R1) ? ka : kb;
  assign fk_out     = fk(work, fk_key);

  // Next-state logic: round states, optional stall gaps, result hold.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = S_R1;
      S_R1:   next_state = HAS_STALL ? S_ST1 : S_R2;
      S_ST1:  if (stall_done) next_state = S_R2;
      S_R2:   next_state = HAS_STALL ? S_ST2 : S_DONE;
      S_ST2:  if (stall_done) next_state = S_DONE;
      S_DONE: if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Control registers: state, stall counter, post-reset live flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stall_cnt <= 2'd0;
      live      <= 1'b0;
    end else begin
      state     <= next_state;
      stall_cnt <= (state == S_ST1 || state == S_ST2) ? stall_cnt + 2'd1 : 2'd0;
      live      <= 1'b1;
    end
  end

  // Datapath: capture block/keys on accept, round 1, result on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= 8'h00;
      ka        <= 8'h00;
      kb        <= 8'h00;
      data_out  <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        work <= ip(data_in);
        ka   <= mode ? key_2 : key_1;
        kb   <= mode ? key_1 : key_2;
      end else if (state == S_R1) begin
        work <= sw(fk_out);
      end
      if (next_state == S_DONE && state != S_DONE) begin
        data_out  <= ip_inv(fk_out);
        out_valid <= 1'b1;
      end else if (state == S_DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SDES_ROUND_DEBUG_EN
  assign dbg_round = work;

  // Debug state view: stall gaps report the round they follow.
  always_comb begin
    dbg_state = 2'd0;
    case (state)
      S_R1, S_ST1: dbg_state = 2'd1;
      S_R2, S_ST2: dbg_state = 2'd2;
      S_DONE:      dbg_state = 2'd3;
      default:     dbg_state = 2'd0;
    endcase
  end
`endif

endmodule
